muldiv_ctrl: RTL and testbench

- Sequences the multi-cycle multiply/divide resources of the EXE stage.
- Accepts a MULT/MULTU/DIV/DIVU op from EX and launches the 32-clock divider with a start pulse and latched operands, or counts out the multiplier latency.
- Holds the pipeline stall until the result is ready, then presents a stable hi/lo result until the pipeline advances.
- Cancels in-flight work on flush or a memory-stage exception.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_lat_cnt.sv | 29 ++
 rtl/muldiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EXE-stage multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIV_BUSY  = 2'd1,
        MULT_BUSY = 2'd2,
        DONE      = 2'd3
    } muldiv_state_t;

    // Width of a {hi,lo} result pair.
    localparam int MULDIV_RES_W = 64;

    // ALU control codes of the multi-cycle ops, same values as the ALU decoder.
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Decode helpers for the stage that drives op_is_div_i / op_is_mult_i.
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

    function automatic logic is_mult_op(input logic [7:0] aluop);
        return (aluop == EXE_MULT_OP) || (aluop == EXE_MULTU_OP);
    endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter with a zero flag. Shared between the multiplier
// latency countdown and the divider watchdog (the two never run together).
module muldiv_lat_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; the count holds at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU resources of the EXE
// stage: launches the divider or times the multiplier, stalls the front of
// the pipe until a result is registered, and holds it until EX advances.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT    = 2,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid_i,
    input  logic                    op_is_div_i,
    input  logic                    op_is_mult_i,
    input  logic [31:0]             op_a_i,
    input  logic [31:0]             op_b_i,
    input  logic                    pipe_stall_i,
    input  logic                    flush_i,
    input  logic [31:0]             mem_excepttype_i,
    input  logic                    div_ready_i,
    input  logic [MULDIV_RES_W-1:0] div_result_i,
    input  logic [MULDIV_RES_W-1:0] mult_result_i,
    output logic                    div_start_o,
    output logic                    div_annul_o,
    output logic [31:0]             div_op_a_o,
    output logic [31:0]             div_op_b_o,
    output logic                    stall_o,
    output logic                    result_valid_o,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o
);

    localparam int CNT_MAX = (DIV_TIMEOUT > MULT_LAT) ? DIV_TIMEOUT : MULT_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    muldiv_state_t           state, state_n;
    logic                    kill;
    logic                    cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]        cnt_val;
    logic                    cap_div, cap_mult, timeout;
    logic [MULDIV_RES_W-1:0] result_q;

    assign kill = flush_i | (mem_excepttype_i != 32'd0);

    muldiv_lat_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state, counter control, capture strobes and stall.
    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        cap_div  = 1'b0;
        cap_mult = 1'b0;
        timeout  = 1'b0;
        stall_o  = 1'b0;
        unique case (state)
            IDLE: begin
                // Div wins if both op flags are (illegally) set.
                if (op_valid_i && op_is_div_i && !kill) begin
                    state_n  = DIV_BUSY;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DIV_TIMEOUT - 1);
                    stall_o  = 1'b1;
                end else if (op_valid_i && op_is_mult_i && !kill) begin
                    state_n  = MULT_BUSY;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(MULT_LAT - 1);
                    stall_o  = 1'b1;
                end
            end
            DIV_BUSY: begin
                // A div_ready_i coincident with kill is dropped.
                if (kill) begin
                    state_n = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (div_ready_i) begin
                        cap_div = 1'b1;
                        state_n = DONE;
                    end else if (cnt_zero) begin
                        timeout = 1'b1;
                        state_n = DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            MULT_BUSY: begin
                if (kill) begin
                    state_n = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_zero) begin
                        cap_mult = 1'b1;
                        state_n  = DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                // Leave only once the instruction moves out of EX, so it is
                // never launched twice.
                if (kill || !pipe_stall_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs: divider handshake pulses, latched operands, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_start_o    <= 1'b0;
            div_annul_o    <= 1'b0;
            div_op_a_o     <= '0;
            div_op_b_o     <= '0;
            result_valid_o <= 1'b0;
            result_q       <= '0;
        end else begin
            div_start_o    <= (state == IDLE) && (state_n == DIV_BUSY);
            div_annul_o    <= (state == DIV_BUSY) && (kill || timeout);
            result_valid_o <= (state_n == DONE);
            if ((state == IDLE) && (state_n == DIV_BUSY)) begin
                div_op_a_o <= op_a_i;
                div_op_b_o <= op_b_i;
            end
            if (cap_div)       result_q <= div_result_i;
            else if (cap_mult) result_q <= mult_result_i;
            else if (timeout)  result_q <= '0;
        end
    end

    assign hi_o = result_q[MULDIV_RES_W-1:MULDIV_RES_W/2];
    assign lo_o = result_q[MULDIV_RES_W/2-1:0];

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a divider/multiplier model driven from
// the bench, with expected stall/pulse/result behaviour derived per cycle.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MULT_LAT    = 2;
    localparam int DIV_TIMEOUT = 40;
    localparam int DIV_LAT     = 32;   // divider readies this many cycles after start

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i, op_is_div_i, op_is_mult_i;
    logic [31:0] op_a_i, op_b_i;
    logic        pipe_stall_i, flush_i;
    logic [31:0] mem_excepttype_i;
    logic        div_ready_i;
    logic [63:0] div_result_i, mult_result_i;
    logic        div_start_o, div_annul_o, stall_o, result_valid_o;
    logic [31:0] div_op_a_o, div_op_b_o, hi_o, lo_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .op_valid_i       (op_valid_i),
        .op_is_div_i      (op_is_div_i),
        .op_is_mult_i     (op_is_mult_i),
        .op_a_i           (op_a_i),
        .op_b_i           (op_b_i),
        .pipe_stall_i     (pipe_stall_i),
        .flush_i          (flush_i),
        .mem_excepttype_i (mem_excepttype_i),
        .div_ready_i      (div_ready_i),
        .div_result_i     (div_result_i),
        .mult_result_i    (mult_result_i),
        .div_start_o      (div_start_o),
        .div_annul_o      (div_annul_o),
        .div_op_a_o       (div_op_a_o),
        .div_op_b_o       (div_op_b_o),
        .stall_o          (stall_o),
        .result_valid_o   (result_valid_o),
        .hi_o             (hi_o),
        .lo_o             (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout compared=%0d", n_cmp);
        $fatal(1, "bench did not finish");
    end

    task automatic idle_inputs();
        op_valid_i       = 1'b0;
        op_is_div_i      = 1'b0;
        op_is_mult_i     = 1'b0;
        op_a_i           = $urandom;
        op_b_i           = $urandom;
        pipe_stall_i     = 1'b0;
        flush_i          = 1'b0;
        mem_excepttype_i = '0;
        div_ready_i      = 1'b0;
        div_result_i     = {$urandom, $urandom};
        mult_result_i    = {$urandom, $urandom};
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // DONE phase shared by div and mult: EX holds for 'hold' cycles, then leaves.
    task automatic done_phase(input string tag, input int hold, input bit annul_first);
        for (int h = 0; h <= hold; h++) begin
            next_cycle();
            pipe_stall_i = (h < hold);
            div_ready_i  = 1'b0;
            div_result_i = {$urandom, $urandom};
            mult_result_i = {$urandom, $urandom};
            settle();
            n_cmp++;
            if ({stall_o, div_start_o, div_annul_o, result_valid_o} !== {1'b0, 1'b0, annul_first && h == 0, 1'b1}) begin
                n_bad++;
                $display("FAIL %s_done_ctl h=%0d stall/start/annul/valid got %b want %b", tag, h,
                         {stall_o, div_start_o, div_annul_o, result_valid_o}, {1'b0, 1'b0, annul_first && h == 0, 1'b1});
            end
            n_cmp++;
            if ({hi_o, lo_o} !== {exp_hi, exp_lo}) begin
                n_bad++;
                $display("FAIL %s_done_result h=%0d got %h_%h want %h_%h", tag, h, hi_o, lo_o, exp_hi, exp_lo);
            end
        end
    endtask

    // One divide. flush_at>0 flushes in that DIV_BUSY cycle; hang never readies.
    task automatic test_div(input logic [31:0] a, input logic [31:0] b, input int hold,
                            input int flush_at, input bit hang);
        logic [63:0] res;
        int          k;
        bit          ready;
        // MIPS convention: hi = remainder, lo = quotient; x/0 is whatever the divider says.
        res = (b != 0) ? {a % b, a / b} : {$urandom, $urandom};
        next_cycle();
        idle_inputs();
        op_valid_i = 1'b1; op_is_div_i = 1'b1; op_a_i = a; op_b_i = b; pipe_stall_i = 1'b1;
        settle();
        n_cmp++;
        if ({stall_o, div_start_o, result_valid_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL div_launch stall/start/valid got %b want 100", {stall_o, div_start_o, result_valid_o});
        end
        k = 0;
        while (1) begin
            k++;
            next_cycle();
            op_a_i = $urandom; op_b_i = $urandom;   // forwarding may move on; latched copy must not
            ready = !hang && (k == 1 + DIV_LAT) && (flush_at == 0);
            div_ready_i  = ready;
            div_result_i = ready ? res : {$urandom, $urandom};
            flush_i      = (k == flush_at);
            settle();
            n_cmp++;
            if ({stall_o, div_start_o, div_annul_o, result_valid_o} !== {k != flush_at, k == 1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL div_busy_ctl k=%0d stall/start/annul/valid got %b want %b", k,
                         {stall_o, div_start_o, div_annul_o, result_valid_o}, {k != flush_at, k == 1, 1'b0, 1'b0});
            end
            n_cmp++;
            if ({div_op_a_o, div_op_b_o} !== {a, b}) begin
                n_bad++;
                $display("FAIL div_operands k=%0d got %h/%h want %h/%h", k, div_op_a_o, div_op_b_o, a, b);
            end
            if (ready || k == flush_at || (hang && k == DIV_TIMEOUT)) break;
            if (k > DIV_TIMEOUT + 2) begin
                n_bad++;
                $display("FAIL div_bound k=%0d exceeded cycle budget", k);
                break;
            end
        end
        if (flush_at != 0) begin
            // After the flush: one annul pulse, nothing valid, late div_ready_i ignored.
            while (k < DIV_LAT + 3) begin
                k++;
                next_cycle();
                idle_inputs();
                div_ready_i  = (k == 1 + DIV_LAT);
                div_result_i = res;
                settle();
                n_cmp++;
                if ({stall_o, div_start_o, div_annul_o, result_valid_o} !== {1'b0, 1'b0, k == flush_at + 1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL div_flush_ctl k=%0d stall/start/annul/valid got %b want %b", k,
                             {stall_o, div_start_o, div_annul_o, result_valid_o}, {1'b0, 1'b0, k == flush_at + 1, 1'b0});
                end
                n_cmp++;
                if ({hi_o, lo_o} !== {exp_hi, exp_lo}) begin
                    n_bad++;
                    $display("FAIL div_flush_result k=%0d got %h_%h want %h_%h", k, hi_o, lo_o, exp_hi, exp_lo);
                end
            end
        end else begin
            {exp_hi, exp_lo} = hang ? 64'd0 : res;
            done_phase(hang ? "div_timeout" : "div", hold, hang);
        end
    endtask

    // One multiply; the model presents a valid product only MULT_LAT cycles after launch.
    task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] res;
        res = 64'(a) * 64'(b);
        next_cycle();
        idle_inputs();
        op_valid_i = 1'b1; op_is_mult_i = 1'b1; op_a_i = a; op_b_i = b; pipe_stall_i = 1'b1;
        settle();
        n_cmp++;
        if ({stall_o, div_start_o, result_valid_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL mult_launch stall/start/valid got %b want 100", {stall_o, div_start_o, result_valid_o});
        end
        for (int k = 1; k <= MULT_LAT; k++) begin
            next_cycle();
            mult_result_i = (k == MULT_LAT) ? res : {$urandom, $urandom};
            settle();
            n_cmp++;
            if ({stall_o, div_start_o, div_annul_o, result_valid_o} !== 4'b1000) begin
                n_bad++;
                $display("FAIL mult_busy_ctl k=%0d stall/start/annul/valid got %b want 1000", k,
                         {stall_o, div_start_o, div_annul_o, result_valid_o});
            end
        end
        {exp_hi, exp_lo} = res;
        done_phase("mult", hold, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        n_cmp++;
        if ({div_start_o, div_annul_o, stall_o, result_valid_o, div_op_a_o, div_op_b_o, hi_o, lo_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got start=%b annul=%b stall=%b valid=%b a=%h b=%h hi=%h lo=%h want all 0",
                     div_start_o, div_annul_o, stall_o, result_valid_o, div_op_a_o, div_op_b_o, hi_o, lo_o);
        end
        rst = 1'b0;
        {exp_hi, exp_lo} = 64'd0;
    endtask

    // A kill in the cycle a div or mult is offered in IDLE must prevent the launch.
    task automatic test_kill_idle();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle_inputs();
            op_valid_i = 1'b1;
            op_is_div_i  = (i < 2);
            op_is_mult_i = (i >= 2);
            if (i[0]) flush_i = 1'b1;
            else      mem_excepttype_i = 32'h4;
            settle();
            n_cmp++;
            if (stall_o !== 1'b0) begin
                n_bad++;
                $display("FAIL kill_idle_stall i=%0d got %b want 0", i, stall_o);
            end
            next_cycle();
            idle_inputs();
            settle();
            n_cmp++;
            if ({stall_o, div_start_o, div_annul_o, result_valid_o} !== 4'b0000) begin
                n_bad++;
                $display("FAIL kill_idle_after i=%0d stall/start/annul/valid got %b want 0000", i,
                         {stall_o, div_start_o, div_annul_o, result_valid_o});
            end
        end
    endtask

    // Memory exception while the multiplier counts: abandon, no annul (not a div).
    task automatic test_kill_mult();
        next_cycle();
        idle_inputs();
        op_valid_i = 1'b1; op_is_mult_i = 1'b1;
        next_cycle();
        mem_excepttype_i = 32'h1;
        settle();
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL kill_mult_stall got %b want 0", stall_o);
        end
        for (int k = 0; k < MULT_LAT + 2; k++) begin
            next_cycle();
            idle_inputs();
            settle();
            n_cmp++;
            if ({stall_o, div_annul_o, result_valid_o} !== 3'b000) begin
                n_bad++;
                $display("FAIL kill_mult_after k=%0d stall/annul/valid got %b want 000", k,
                         {stall_o, div_annul_o, result_valid_o});
            end
        end
    endtask

    // Asynchronous reset in the middle of a divide: straight to idle, no annul.
    task automatic test_reset_mid();
        next_cycle();
        idle_inputs();
        op_valid_i = 1'b1; op_is_div_i = 1'b1;
        repeat (5) next_cycle();
        idle_inputs();
        rst = 1'b1;
        settle();
        n_cmp++;
        if ({stall_o, div_start_o, div_annul_o, result_valid_o, hi_o, lo_o, div_op_a_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid got stall=%b start=%b annul=%b valid=%b hi=%h lo=%h a=%h want all 0",
                     stall_o, div_start_o, div_annul_o, result_valid_o, hi_o, lo_o, div_op_a_o);
        end
        {exp_hi, exp_lo} = 64'd0;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            n_cmp++;
            if ({stall_o, div_annul_o, result_valid_o} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_mid_after k=%0d stall/annul/valid got %b want 000", k,
                         {stall_o, div_annul_o, result_valid_o});
            end
        end
    endtask

    task automatic test_back_to_back();
        test_mult($urandom, $urandom, 0);
        test_div($urandom, $urandom_range(1, 1000), 0, 0, 1'b0);
        test_mult($urandom, $urandom, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0)
                test_div($urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31),
                         $urandom_range(0, 3), 0, 1'b0);
            else
                test_mult($urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_div(32'd100, 32'd7, 0, 0, 1'b0);
        test_mult(32'h0001_0000, 32'h0001_0000, 0);
        test_div($urandom, $urandom_range(1, 50), 5, 0, 1'b0);
        test_div($urandom, $urandom_range(1, 50), 0, 10, 1'b0);
        test_kill_idle();
        test_div($urandom, $urandom, 1, 0, 1'b1);
        test_div($urandom, 32'd0, 0, 0, 1'b0);
        test_back_to_back();
        test_kill_mult();
        test_reset_mid();
        test_random();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
